// File: rtl/pipe_gap_gen.sv
// pipe_gap_gen: picks the gap-centre row for each new pipe.
// On a spawn request the LFSR is enabled for SETTLE cycles, then one random
// byte is captured and reduced modulo GAP_RANGE. The result is offset by
// GAP_MIN and clamped so consecutive gaps differ by at most MAX_STEP. The
// result is then offered on a valid/ready handshake. A request that arrives
// while busy is remembered in a one-deep pending flag.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   spawn_req           request a new gap
//   rnd_in / rnd_en     random byte from / enable to the LFSR
//   gap_y, gap_valid    new gap row and its valid flag
//   gap_ready           consumer accepts gap_y
//   busy                high whenever the FSM is not idle
module pipe_gap_gen #(
  parameter logic [7:0] GAP_MIN   = 8'd40,
  parameter logic [7:0] GAP_RANGE = 8'd120,
  parameter logic [7:0] MAX_STEP  = 8'd60,
  parameter logic [3:0] SETTLE    = 4'd9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       spawn_req,
  input  logic [7:0] rnd_in,
  output logic       rnd_en,
  output logic [7:0] gap_y,
  output logic       gap_valid,
  input  logic       gap_ready,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, FILL, CAPTURE, REDUCE, CLAMP, PRESENT} state_t;

  state_t     state, state_nxt;
  logic [3:0] fill_cnt, fill_cnt_nxt;
  logic [7:0] val, val_nxt;
  logic [7:0] prev, prev_nxt;
  logic [7:0] gap_nxt;
  logic       pend, pend_nxt;

  logic [8:0] cand;
  logic [8:0] cand_hi;
  logic [9:0] cand_lo;

  // Clamp arithmetic is widened so no comparison can wrap.
  assign cand    = {1'b0, GAP_MIN} + {1'b0, val};
  assign cand_hi = {1'b0, prev} + {1'b0, MAX_STEP};
  assign cand_lo = {1'b0, cand} + {2'b00, MAX_STEP};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fill_cnt <= '0;
      val      <= '0;
      prev     <= GAP_MIN;
      gap_y    <= GAP_MIN;
      pend     <= 1'b0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_cnt_nxt;
      val      <= val_nxt;
      prev     <= prev_nxt;
      gap_y    <= gap_nxt;
      pend     <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fill_cnt_nxt = fill_cnt;
    val_nxt      = val;
    prev_nxt     = prev;
    gap_nxt      = gap_y;
    pend_nxt     = pend;
    rnd_en       = 1'b0;
    gap_valid    = 1'b0;
    busy         = (state != IDLE);

    // Any request while busy (including the handshake cycle) is remembered once.
    if (state != IDLE && spawn_req) begin
      pend_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (spawn_req || pend) begin
          state_nxt    = FILL;
          pend_nxt     = 1'b0;
          fill_cnt_nxt = '0;
        end
      end
      FILL: begin
        rnd_en       = 1'b1;
        fill_cnt_nxt = fill_cnt + 4'd1;
        if (fill_cnt == SETTLE - 4'd1) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        val_nxt   = rnd_in;
        state_nxt = REDUCE;
      end
      REDUCE: begin
        if (val >= GAP_RANGE) begin
          val_nxt = val - GAP_RANGE;
        end else begin
          state_nxt = CLAMP;
        end
      end
      CLAMP: begin
        if (cand > cand_hi) begin
          gap_nxt = cand_hi[7:0];
        end else if (cand_lo < {2'b00, prev}) begin
          gap_nxt = prev - MAX_STEP;
        end else begin
          gap_nxt = cand[7:0];
        end
        prev_nxt  = gap_nxt;
        state_nxt = PRESENT;
      end
      PRESENT: begin
        gap_valid = 1'b1;
        if (gap_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_gap_gen.sv
module tb_pipe_gap_gen;

  localparam int GMIN   = 40;
  localparam int GRANGE = 120;
  localparam int MSTEP  = 60;
  localparam int NSET   = 9;

  logic       clock;
  logic       reset;
  logic       spawn_req;
  logic [7:0] rnd_in;
  logic       rnd_en;
  logic [7:0] gap_y;
  logic       gap_valid;
  logic       gap_ready;
  logic       busy;

  logic       spawn2;
  logic [7:0] rnd2;
  logic       rnd_en2;
  logic [7:0] gap_y2;
  logic       gap_valid2;
  logic       ready2;
  logic       busy2;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_gap_gen #(
    .GAP_MIN  (8'd40),
    .GAP_RANGE(8'd120),
    .MAX_STEP (8'd60),
    .SETTLE   (4'd9)
  ) u_dut (
    .clock    (clock),
    .reset    (reset),
    .spawn_req(spawn_req),
    .rnd_in   (rnd_in),
    .rnd_en   (rnd_en),
    .gap_y    (gap_y),
    .gap_valid(gap_valid),
    .gap_ready(gap_ready),
    .busy     (busy)
  );

  // Second instance: a single legal row, so 255 needs 255 subtractions.
  pipe_gap_gen #(
    .GAP_MIN  (8'd40),
    .GAP_RANGE(8'd1),
    .MAX_STEP (8'd60),
    .SETTLE   (4'd9)
  ) u_dut1 (
    .clock    (clock),
    .reset    (reset),
    .spawn_req(spawn2),
    .rnd_in   (rnd2),
    .rnd_en   (rnd_en2),
    .gap_y    (gap_y2),
    .gap_valid(gap_valid2),
    .gap_ready(ready2),
    .busy     (busy2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction schedule: a request accepted at edge s enables the LFSR for
  // cycles s..s+SETTLE-1, samples rnd_in at edge s+SETTLE+1, and presents
  // the clamped gap k+2 edges later (k = rnd / GAP_RANGE).
  int   n;
  bit   m_busy, m_pend, m_pres;
  int   m_s, m_pres_edge, m_gap, m_prev, m_next;
  bit   chk_en = 1'b0;
  bit   last_valid = 1'b0;
  int   dut_gaps = 0;

  function automatic int clampf(input int cand, input int prev);
    if (cand > prev + MSTEP) return (prev + MSTEP) % 256;
    if (cand + MSTEP < prev) return prev - MSTEP;
    return cand;
  endfunction

  task automatic model_clear();
    m_busy = 0; m_pend = 0; m_pres = 0;
    m_s = 0; m_pres_edge = -1;
    m_gap = GMIN; m_prev = GMIN; m_next = GMIN;
  endtask

  task automatic model_step(input bit sp, input int rd, input bit rdy);
    n++;
    if (!m_busy) begin
      if (sp || m_pend) begin
        m_busy = 1; m_pend = 0; m_s = n; m_pres_edge = -1;
      end
    end else begin
      if (sp) m_pend = 1;
      if (n == m_s + NSET + 1) begin
        m_pres_edge = n + rd / GRANGE + 2;
        m_next = clampf(GMIN + rd % GRANGE, m_prev);
      end else if (m_pres && rdy) begin
        m_pres = 0; m_busy = 0;
      end else if (n == m_pres_edge) begin
        m_gap = m_next; m_prev = m_next; m_pres = 1;
      end
    end
  endtask

  initial begin : compare
    n = 0;
    model_clear();
    forever begin
      @(posedge clock);
      if (reset) model_clear();
      else model_step(spawn_req, int'(rnd_in), gap_ready);
      @(negedge clock);
      if (gap_valid && !last_valid) dut_gaps++;
      last_valid = gap_valid;
      if (chk_en) begin
        check("busy", busy, m_busy);
        check("rnd_en", rnd_en, m_busy && !m_pres && (n - m_s) < NSET);
        check("gap_valid", gap_valid, m_pres);
        check("gap_y", gap_y, m_gap);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_req(input logic [7:0] r, output int lat, output int en_cnt, output int gy);
    @(negedge clock);
    rnd_in = r; gap_ready = 1'b1; spawn_req = 1'b1;
    @(negedge clock);
    spawn_req = 1'b0;
    lat = -1; en_cnt = 0; gy = -1;
    for (int i = 0; i < 400; i++) begin
      if (rnd_en) en_cnt++;
      if (gap_valid) begin
        lat = i; gy = int'(gap_y);
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    check("valid_one_cycle", gap_valid, 0);
  endtask

  int lat, enc, gy, g0;

  initial begin : stim
    reset = 1'b1; spawn_req = 1'b0; rnd_in = '0; gap_ready = 1'b0;
    spawn2 = 1'b0; rnd2 = '0; ready2 = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_rnd_en", rnd_en, 0);
    check("rst_valid", gap_valid, 0);
    check("rst_gap_y", gap_y, 40);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk_en = 1'b1;

    // First gap: cand 120 clamped to 40+60.
    do_req(8'd200, lat, enc, gy);
    check("req200_lat", lat, 13);
    check("req200_en", enc, 9);
    check("req200_gap", gy, 100);

    // cand 50 within reach of 100.
    do_req(8'd10, lat, enc, gy);
    check("req10_lat", lat, 12);
    check("req10_gap", gy, 50);

    // Backpressure: cand 159 clamped to 110, held for 20 cycles.
    @(negedge clock);
    rnd_in = 8'd119; gap_ready = 1'b0; spawn_req = 1'b1;
    @(negedge clock);
    spawn_req = 1'b0;
    for (int i = 0; i < 100 && !gap_valid; i++) @(negedge clock);
    check("bp_gap", gap_y, 110);
    for (int i = 0; i < 20; i++) begin
      check("bp_valid_hold", gap_valid, 1);
      check("bp_gap_hold", gap_y, 110);
      @(negedge clock);
    end
    gap_ready = 1'b1;
    @(negedge clock);
    check("bp_done", gap_valid, 0);

    // Three requests in one busy period -> two gaps (159 then 159).
    g0 = dut_gaps;
    @(negedge clock);
    rnd_in = 8'd119; spawn_req = 1'b1;
    @(negedge clock); spawn_req = 1'b0;
    repeat (3) @(negedge clock);
    spawn_req = 1'b1;
    @(negedge clock); spawn_req = 1'b0;
    repeat (4) @(negedge clock);
    spawn_req = 1'b1;
    @(negedge clock); spawn_req = 1'b0;
    repeat (60) @(negedge clock);
    check("three_req_gaps", dut_gaps - g0, 2);
    check("three_req_gap", gap_y, 159);

    // Lower clamp: prev 159, cand 40 -> 99.
    do_req(8'd0, lat, enc, gy);
    check("low_clamp_lat", lat, 12);
    check("low_clamp_gap", gy, 99);

    // Reset while in REDUCE aborts the request.
    @(negedge clock);
    rnd_in = 8'd255; spawn_req = 1'b1;
    @(negedge clock);
    spawn_req = 1'b0;
    repeat (10) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("abort_valid", gap_valid, 0);
    check("abort_rnd_en", rnd_en, 0);
    check("abort_busy", busy, 0);
    check("abort_gap_y", gap_y, 40);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    g0 = dut_gaps;
    repeat (40) @(negedge clock);
    check("abort_no_gap", dut_gaps - g0, 0);
    check("abort_idle", busy, 0);

    // prev was reset to 40, so 200 clamps to 100 again.
    do_req(8'd200, lat, enc, gy);
    check("post_rst_gap", gy, 100);

    // GAP_RANGE=1 instance: 256 REDUCE cycles, val 0 -> gap 40.
    @(negedge clock);
    rnd2 = 8'd255; spawn2 = 1'b1;
    @(negedge clock);
    spawn2 = 1'b0;
    lat = -1; enc = 0; gy = -1;
    for (int i = 0; i < 400; i++) begin
      if (rnd_en2) enc++;
      if (gap_valid2) begin
        lat = i; gy = int'(gap_y2);
        break;
      end
      @(negedge clock);
    end
    check("range1_lat", lat, 9 + 1 + 256 + 1);
    check("range1_en", enc, 9);
    check("range1_gap", gy, 40);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      spawn_req = ($urandom_range(0, 5) == 0);
      rnd_in    = 8'($urandom);
      gap_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clock);
    spawn_req = 1'b0; gap_ready = 1'b1;
    repeat (80) @(negedge clock);
    check("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
